cond_ring_sequencer: RTL and testbench
======================================

Name: cond_ring_sequencer

Overview:
Parametrised ring-sequencing state machine. It generalises the fixed 4-state, 4-condition sequencer to N states, with selectable direction, a dwell-timeout fault state, synchronous clear, one-hot output and a wrap pulse. It sits in control paths where each step waits on its own qualifying condition before the sequence advances.

Parameters:
N_STATES, 4, number of ring states; must be ≥2 and need not be a power of two.
TIMEOUT, 15, number of consecutive enabled non-advancing cycles in one state before FAULT; 0 disables the timeout.
W (localparam), $clog2(N_STATES) (minimum 1), width of the state index.
CW (localparam), $clog2(TIMEOUT+1) (minimum 1), width of the dwell counter.

Ports:
clk     input   1         system clock; all state updates on its rising edge.
rst     input   1         asynchronous reset, active-high.
en      input   1         step enable; when 0, state and dwell counter hold.
clr     input   1         synchronous clear: return to S0 and clear a fault; independent of en.
dir     input   1         0 = forward (i → i+1), 1 = reverse (i → i−1).
a       input   N_STATES  per-state advance conditions; only a[current index] is examined.
y       output  W         registered index of the current state.
onehot  output  N_STATES  registered one-hot of the current state; all zeros in FAULT.
wrap    output  1         registered one-cycle pulse marking a ring wrap.
fault   output  1         registered; high while in FAULT.

Behaviour:
- States: S_0 .. S_{N_STATES-1}, plus FAULT.
- Reset (asynchronous, rst=1), applied immediately without a clock edge:
  - state=S_0, y=0, onehot=1 (bit 0 set).
  - wrap=0, fault=0, dwell counter=0.
- Per-edge priority: rst > clr > advance > timeout > hold.
- clr=1: next state is S_0, dwell=0, fault=0, wrap=0. It applies from any state, including FAULT, regardless of en.
- In S_i with en=1 and a[i]=1 (advance):
  - forward target: (i+1) mod N_STATES.
  - reverse target: (i−1) mod N_STATES.
  - dwell is cleared to 0.
- dir is sampled on the same edge as a[i]; a direction change takes effect on the very next advance.
- Wrap:
  - wrap=1 for exactly one cycle, aligned with the new y, after a forward S_{N-1}→S_0 or reverse S_0→S_{N-1} transition.
  - Otherwise wrap=0.
- Wrap is computed explicitly against N_STATES−1; y never exceeds N_STATES−1 for non-power-of-two N.
- In S_i with en=1 and a[i]=0 (dwell), when TIMEOUT≠0:
  - if dwell==TIMEOUT−1: next state is FAULT, dwell=0.
  - else: dwell increments.
  - Net effect: FAULT is entered on the edge ending the TIMEOUT-th consecutive enabled non-advancing cycle.
  - An advance on that same cycle wins; no fault is raised.
- TIMEOUT=0: the dwell counter stays at 0 and FAULT is unreachable.
- en=0: state, y, onehot and dwell all hold; wrap=0. en does not reset dwell.
- FAULT:
  - fault=1, onehot=0.
  - y holds the index of the state that timed out.
  - en, dir and a are ignored; exit is only via clr or rst.
- Simultaneous clr and advance: clr wins (S_0, wrap=0).
- Condition bits a[j] for j≠current index have no effect.
- All outputs are registers; there are no combinational paths from inputs to outputs.
- Advance latency: a[i] sampled at edge k gives new y/onehot/wrap valid after edge k.

Test Plan:
1. Async reset: run to y=2, pulse rst=1 between clock edges → y=0, onehot=0001, fault=0 immediately, with no edge required.
2. Forward walk (N=4): en=1, dir=0, apply a=0001, 0010, 0100, 1000 for one cycle each → y=1,2,3,0; wrap=1 only on the cycle y returns to 0. Apply a=1110 in S0 → no advance.
3. Hold: en=0 with a=1111 for 3 cycles in S1 → y=1 throughout, wrap=0. Then re-enable with a=0000 → dwell resumes from its frozen count, not from 0.
4. Reverse: dir=1 in S0, a=0001 → y=3, wrap=1. Then a=1000 → y=2, wrap=0. Switch dir=0, a=0100 → y=3.
5. Timeout (TIMEOUT=15), part A: in S2 with en=1, a=0 → 14 cycles no fault; 15th edge gives fault=1, onehot=0000, y=2. Apply a=1111 → no change; clr=1 → y=0, onehot=0001, fault=0.
6. Timeout part B: repeat the hold with a[2]=1 on the 15th cycle → y=3, no fault.
7. N_STATES=5, TIMEOUT=0 instance: forward walk wraps 4→0 with a wrap pulse, y never 5–7. Hold in S3 for 100 cycles → fault stays 0. clr and advance in the same cycle → y=0, wrap=0.

Source files
------------

// File: rtl/cond_ring_sequencer.sv
// ---------------------------------------------------------------------------
// cond_ring_sequencer
//
// Ring sequencer over N_STATES steps. Each step waits for its own advance
// condition a[current index] and then moves one position forward or backward
// around the ring. If a step stays enabled without advancing for TIMEOUT
// consecutive cycles, the sequencer parks in FAULT. Only clr or rst leave
// FAULT.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous reset, active-high
//   en      - step enable; state and dwell counter hold while low
//   clr     - synchronous clear back to S0 (clears FAULT), ignores en
//   dir     - 0 = forward (i -> i+1), 1 = reverse (i -> i-1)
//   a       - per-state advance conditions; only a[current index] matters
//   y       - registered index of the current state
//   onehot  - registered one-hot of the current state, all zeros in FAULT
//   wrap    - registered one-cycle pulse on a ring wrap
//   fault   - registered, high while in FAULT
// ---------------------------------------------------------------------------
module cond_ring_sequencer #(
  parameter int N_STATES = 4,
  parameter int TIMEOUT  = 15,
  localparam int W  = ($clog2(N_STATES) < 1) ? 1 : $clog2(N_STATES),
  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                dir,
  input  logic [N_STATES-1:0] a,
  output logic [W-1:0]        y,
  output logic [N_STATES-1:0] onehot,
  output logic                wrap,
  output logic                fault
);

  // Last ring index; wrap detection compares against this rather than relying
  // on natural overflow, so non-power-of-two rings stay in range.
  localparam logic [W-1:0] LAST_IDX = W'(N_STATES - 1);

  // Dwell count at which the next non-advancing cycle raises FAULT.
  localparam int TMO_M1 = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_M1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } mode_t;

  mode_t         mode_r;
  logic [CW-1:0] dwell_r;

  logic          adv_s;
  logic [W-1:0]  next_idx_s;
  logic          wrap_s;
  logic          tmo_hit_s;

  // Decode a ring index into its one-hot pattern.
  function automatic logic [N_STATES-1:0] onehot_of(input logic [W-1:0] idx);
    logic [N_STATES-1:0] res;
    res = {N_STATES{1'b0}};
    for (int i = 0; i < N_STATES; i++) begin
      res[i] = (idx == W'(i));
    end
    return res;
  endfunction

  // Next-step decode: qualifying condition, target index, wrap and timeout hit.
  always_comb begin
    adv_s      = 1'b0;
    next_idx_s = y;
    wrap_s     = 1'b0;
    tmo_hit_s  = 1'b0;

    // onehot mirrors the current index in RUN and is zero in FAULT, so
    // masking a with it selects exactly a[current index].
    adv_s = |(a & onehot);

    if (dir) begin
      if (y == {W{1'b0}}) begin
        next_idx_s = LAST_IDX;
        wrap_s     = 1'b1;
      end else begin
        next_idx_s = y - W'(1);
        wrap_s     = 1'b0;
      end
    end else begin
      if (y == LAST_IDX) begin
        next_idx_s = {W{1'b0}};
        wrap_s     = 1'b1;
      end else begin
        next_idx_s = y + W'(1);
        wrap_s     = 1'b0;
      end
    end

    if (TIMEOUT != 0) begin
      tmo_hit_s = (dwell_r == TMO_LAST);
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Sequencer FSM: priority rst > clr > advance > timeout > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= ST_RUN;
      y       <= {W{1'b0}};
      onehot  <= onehot_of({W{1'b0}});
      wrap    <= 1'b0;
      fault   <= 1'b0;
      dwell_r <= {CW{1'b0}};
    end else if (clr) begin
      mode_r  <= ST_RUN;
      y       <= {W{1'b0}};
      onehot  <= onehot_of({W{1'b0}});
      wrap    <= 1'b0;
      fault   <= 1'b0;
      dwell_r <= {CW{1'b0}};
    end else begin
      case (mode_r)
        ST_RUN: begin
          wrap <= 1'b0;
          if (en) begin
            if (adv_s) begin
              y       <= next_idx_s;
              onehot  <= onehot_of(next_idx_s);
              wrap    <= wrap_s;
              dwell_r <= {CW{1'b0}};
            end else if (TIMEOUT != 0) begin
              if (tmo_hit_s) begin
                // y keeps the index of the step that timed out.
                mode_r  <= ST_FAULT;
                fault   <= 1'b1;
                onehot  <= {N_STATES{1'b0}};
                dwell_r <= {CW{1'b0}};
              end else begin
                dwell_r <= dwell_r + CW'(1);
              end
            end else begin
              dwell_r <= {CW{1'b0}};
            end
          end else begin
            // Disabled: everything holds, including the dwell count.
            dwell_r <= dwell_r;
          end
        end
        ST_FAULT: begin
          // Parked until clr or rst; en, dir and a are ignored.
          wrap  <= 1'b0;
          fault <= 1'b1;
        end
        default: begin
          mode_r  <= ST_FAULT;
          fault   <= 1'b1;
          onehot  <= {N_STATES{1'b0}};
          wrap    <= 1'b0;
          dwell_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_ring_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cond_ring_sequencer
//
// Directed bench for cond_ring_sequencer. Instance "dut_a" is the default
// N_STATES=4 / TIMEOUT=15 configuration; instance "dut_b" is N_STATES=5 /
// TIMEOUT=0. Inputs change 1 ns after a rising edge, outputs are checked at
// that same point, so every check sees the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_cond_ring_sequencer;

  logic       clk;
  logic       rst;

  logic       en_a, clr_a, dir_a;
  logic [3:0] a_a;
  logic [1:0] y_a;
  logic [3:0] onehot_a;
  logic       wrap_a, fault_a;

  logic       en_b, clr_b, dir_b;
  logic [4:0] a_b;
  logic [2:0] y_b;
  logic [4:0] onehot_b;
  logic       wrap_b, fault_b;

  int n_tests = 0;
  int n_fail  = 0;

  cond_ring_sequencer #(.N_STATES(4), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .dir(dir_a), .a(a_a),
    .y(y_a), .onehot(onehot_a), .wrap(wrap_a), .fault(fault_a)
  );

  cond_ring_sequencer #(.N_STATES(5), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .dir(dir_b), .a(a_b),
    .y(y_b), .onehot(onehot_b), .wrap(wrap_b), .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] ey, input logic [3:0] eoh,
                       input logic ew, input logic ef);
    chk({tag, ".y"},      {30'd0, y_a},      {30'd0, ey});
    chk({tag, ".onehot"}, {28'd0, onehot_a}, {28'd0, eoh});
    chk({tag, ".wrap"},   {31'd0, wrap_a},   {31'd0, ew});
    chk({tag, ".fault"},  {31'd0, fault_a},  {31'd0, ef});
  endtask

  task automatic chk_b(input string tag, input logic [2:0] ey, input logic [4:0] eoh,
                       input logic ew, input logic ef);
    chk({tag, ".y"},      {29'd0, y_b},      {29'd0, ey});
    chk({tag, ".onehot"}, {27'd0, onehot_b}, {27'd0, eoh});
    chk({tag, ".wrap"},   {31'd0, wrap_b},   {31'd0, ew});
    chk({tag, ".fault"},  {31'd0, fault_b},  {31'd0, ef});
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; clr_a = 1'b0; dir_a = 1'b0; a_a = 4'b0000;
    en_b = 1'b0; clr_b = 1'b0; dir_b = 1'b0; a_b = 5'b00000;
    #12;
    rst = 1'b0;
    #1;
    chk_a("reset_a", 2'd0, 4'b0001, 1'b0, 1'b0);
    chk_b("reset_b", 3'd0, 5'b00001, 1'b0, 1'b0);

    // Forward walk around the 4-ring.
    en_a = 1'b1; dir_a = 1'b0;
    a_a = 4'b0001; step(); chk_a("fwd_s1", 2'd1, 4'b0010, 1'b0, 1'b0);
    a_a = 4'b0010; step(); chk_a("fwd_s2", 2'd2, 4'b0100, 1'b0, 1'b0);
    a_a = 4'b0100; step(); chk_a("fwd_s3", 2'd3, 4'b1000, 1'b0, 1'b0);
    a_a = 4'b1000; step(); chk_a("fwd_wrap", 2'd0, 4'b0001, 1'b1, 1'b0);
    a_a = 4'b1110; step(); chk_a("other_bits", 2'd0, 4'b0001, 1'b0, 1'b0);

    // Async reset from S2 with no clock edge involved.
    a_a = 4'b0001; step();
    a_a = 4'b0010; step(); chk_a("pre_rst", 2'd2, 4'b0100, 1'b0, 1'b0);
    a_a = 4'b0000; en_a = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 2'd0, 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    #1;

    // Hold: dwell 2 in S1, freeze for 3 cycles, then 13 more cycles to FAULT.
    en_a = 1'b1; a_a = 4'b0001; step(); chk_a("hold_s1", 2'd1, 4'b0010, 1'b0, 1'b0);
    a_a = 4'b0000; step(); step();
    en_a = 1'b0; a_a = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(); chk_a("hold_en0", 2'd1, 4'b0010, 1'b0, 1'b0);
    end
    en_a = 1'b1; a_a = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    chk_a("hold_resume_12", 2'd1, 4'b0010, 1'b0, 1'b0);
    step(); chk_a("hold_resume_13", 2'd1, 4'b0000, 1'b0, 1'b1);
    clr_a = 1'b1; en_a = 1'b0; step(); chk_a("clr_fault1", 2'd0, 4'b0001, 1'b0, 1'b0);
    clr_a = 1'b0;

    // Reverse, then direction change on the next advance.
    en_a = 1'b1; dir_a = 1'b1;
    a_a = 4'b0001; step(); chk_a("rev_wrap", 2'd3, 4'b1000, 1'b1, 1'b0);
    a_a = 4'b1000; step(); chk_a("rev_s2", 2'd2, 4'b0100, 1'b0, 1'b0);
    dir_a = 1'b0; a_a = 4'b0100; step(); chk_a("dir_flip", 2'd3, 4'b1000, 1'b0, 1'b0);

    // Timeout A: in S2, 14 idle cycles are safe, the 15th faults.
    dir_a = 1'b1; a_a = 4'b1000; step(); chk_a("to_s2", 2'd2, 4'b0100, 1'b0, 1'b0);
    dir_a = 1'b0; a_a = 4'b0000;
    for (int i = 0; i < 14; i++) step();
    chk_a("to_14", 2'd2, 4'b0100, 1'b0, 1'b0);
    step(); chk_a("to_15", 2'd2, 4'b0000, 1'b0, 1'b1);
    a_a = 4'b1111; dir_a = 1'b1; step(); chk_a("fault_sticky", 2'd2, 4'b0000, 1'b0, 1'b1);
    clr_a = 1'b1; step(); chk_a("clr_fault2", 2'd0, 4'b0001, 1'b0, 1'b0);
    clr_a = 1'b0; dir_a = 1'b0;

    // Timeout B: advance on the 15th cycle beats the timeout.
    a_a = 4'b0001; step();
    a_a = 4'b0010; step(); chk_a("tob_s2", 2'd2, 4'b0100, 1'b0, 1'b0);
    a_a = 4'b0000;
    for (int i = 0; i < 14; i++) step();
    a_a = 4'b0100; step(); chk_a("tob_adv", 2'd3, 4'b1000, 1'b0, 1'b0);

    // clr and a wrapping advance on the same edge: clr wins.
    clr_a = 1'b1; a_a = 4'b1000; step(); chk_a("clr_vs_adv_a", 2'd0, 4'b0001, 1'b0, 1'b0);
    clr_a = 1'b0; en_a = 1'b0; a_a = 4'b0000;

    // 5-state ring without timeout.
    en_b = 1'b1; dir_b = 1'b0;
    a_b = 5'b00001; step(); chk_b("b_s1", 3'd1, 5'b00010, 1'b0, 1'b0);
    a_b = 5'b00010; step(); chk_b("b_s2", 3'd2, 5'b00100, 1'b0, 1'b0);
    a_b = 5'b00100; step(); chk_b("b_s3", 3'd3, 5'b01000, 1'b0, 1'b0);
    a_b = 5'b01000; step(); chk_b("b_s4", 3'd4, 5'b10000, 1'b0, 1'b0);
    a_b = 5'b10000; step(); chk_b("b_wrap", 3'd0, 5'b00001, 1'b1, 1'b0);
    dir_b = 1'b1; a_b = 5'b00001; step(); chk_b("b_rev_wrap", 3'd4, 5'b10000, 1'b1, 1'b0);
    a_b = 5'b10000; step(); chk_b("b_rev_s3", 3'd3, 5'b01000, 1'b0, 1'b0);
    dir_b = 1'b0; a_b = 5'b00000;
    for (int i = 0; i < 100; i++) begin
      step(); chk({"b_no_fault"}, {31'd0, fault_b}, 32'd0);
    end
    chk_b("b_hold100", 3'd3, 5'b01000, 1'b0, 1'b0);
    clr_b = 1'b1; a_b = 5'b01000; step(); chk_b("b_clr_vs_adv", 3'd0, 5'b00001, 1'b0, 1'b0);
    clr_b = 1'b0; en_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
